// File: rtl/wrf_arb_pkg.sv
// Purpose : shared types and constants for the two-source WRF frame arbiter.
// Latency : n/a (types only).
// Backpress: n/a (types only).
package wrf_arb_pkg;

    localparam int c_wrf_data_width = 16;
    localparam int c_wrf_addr_width = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } t_arb_state;

    typedef struct packed {
        logic [c_wrf_data_width-1:0]   dat;
        logic [c_wrf_addr_width-1:0]   adr;
        logic [c_wrf_data_width/8-1:0] sel;
        logic                          cyc;
        logic                          stb;
        logic                          we;
    } t_wrf_req;

    typedef struct packed {
        logic stall;
        logic ack;
        logic err;
    } t_wrf_rsp;

    // Master side parked: no cycle, no strobe, all fields zero.
    localparam t_wrf_req c_wrf_req_idle = '0;
    // What a requester that does not own the sink sees.
    localparam t_wrf_rsp c_wrf_rsp_stalled = '{stall: 1'b1, ack: 1'b0, err: 1'b0};

endpackage

// File: rtl/wrf_arb_stats.sv
// Purpose : per-port completed-frame counters for the WRF arbiter.
// Latency : count visible 1 cycle after the frame-done pulse.
// Backpress: none; counts free-run and wrap at 0xFFFF.
// Ports   : clk/rst (sync, active-high); clr synchronous clear (wins over a
//           coincident increment); done0/done1 one-cycle frame-end pulses;
//           frames0/frames1 current counts.
module wrf_arb_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        done0,
    input  logic        done1,
    output logic [15:0] frames0,
    output logic [15:0] frames1
);

    logic [15:0] cnt0;
    logic [15:0] cnt1;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt0 <= 16'd0;
            cnt1 <= 16'd0;
        end else begin
            if (done0) cnt0 <= cnt0 + 16'd1;
            if (done1) cnt1 <= cnt1 + 16'd1;
        end
    end

    assign frames0 = cnt0;
    assign frames1 = cnt1;

endmodule

// File: rtl/wrf_frame_arbiter.sv
// Purpose : frame-level round-robin arbiter sharing one WRF sink between two WRF sources.
// Latency : grant 1 cycle after cyc rises while idle; data and responses pass through combinationally while owned.
// Backpress: non-owner held at stall=1/ack=0 indefinitely; owner sees src_stall_i unchanged.
// Ports   : clk_sys_i, rst_i (synchronous, active-high); snk0_*/snk1_* requester WRF
//           slave ports; src_* shared WRF master port; grant_o one-hot owner (00 = idle).
// Build   : define WRF_ARB_STATS_EN to add stats_clr_i, frames0_o and frames1_o.
module wrf_frame_arbiter
    import wrf_arb_pkg::*;
#(
    parameter int g_data_width = c_wrf_data_width,
    parameter int g_addr_width = c_wrf_addr_width
) (
    input  logic                      clk_sys_i,
    input  logic                      rst_i,

    input  logic [g_data_width-1:0]   snk0_dat_i,
    input  logic [g_addr_width-1:0]   snk0_adr_i,
    input  logic [g_data_width/8-1:0] snk0_sel_i,
    input  logic                      snk0_cyc_i,
    input  logic                      snk0_stb_i,
    input  logic                      snk0_we_i,
    output logic                      snk0_stall_o,
    output logic                      snk0_ack_o,
    output logic                      snk0_err_o,

    input  logic [g_data_width-1:0]   snk1_dat_i,
    input  logic [g_addr_width-1:0]   snk1_adr_i,
    input  logic [g_data_width/8-1:0] snk1_sel_i,
    input  logic                      snk1_cyc_i,
    input  logic                      snk1_stb_i,
    input  logic                      snk1_we_i,
    output logic                      snk1_stall_o,
    output logic                      snk1_ack_o,
    output logic                      snk1_err_o,

    output logic [g_data_width-1:0]   src_dat_o,
    output logic [g_addr_width-1:0]   src_adr_o,
    output logic [g_data_width/8-1:0] src_sel_o,
    output logic                      src_cyc_o,
    output logic                      src_stb_o,
    output logic                      src_we_o,
    input  logic                      src_stall_i,
    input  logic                      src_ack_i,
    input  logic                      src_err_i,

`ifdef WRF_ARB_STATS_EN
    input  logic                      stats_clr_i,
    output logic [15:0]               frames0_o,
    output logic [15:0]               frames1_o,
`endif

    output logic [1:0]                grant_o
);

    t_arb_state state;
    t_arb_state state_nxt;
    // Port that owned the previous frame; the other port wins a tie.
    logic       last_grant;
    logic       last_grant_nxt;

    t_wrf_rsp   src_rsp;
    t_wrf_rsp   rsp0;
    t_wrf_rsp   rsp1;

    // State register
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Next state. A grant is only taken from IDLE, so every frame is followed
    // by at least one cycle with src_cyc_o low, even when the same port re-requests.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (snk0_cyc_i && snk1_cyc_i) begin
                    state_nxt = last_grant ? OWN0 : OWN1;
                end else if (snk0_cyc_i) begin
                    state_nxt = OWN0;
                end else if (snk1_cyc_i) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (!snk0_cyc_i) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = 1'b0;
                end
            end
            OWN1: begin
                if (!snk1_cyc_i) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign src_rsp = '{stall: src_stall_i, ack: src_ack_i, err: src_err_i};

    // Outputs. Responses arriving while IDLE (late acks from a frame that was
    // abandoned with transfers outstanding) fall on the floor here.
    always_comb begin
        src_dat_o = '0;
        src_adr_o = '0;
        src_sel_o = '0;
        src_cyc_o = 1'b0;
        src_stb_o = 1'b0;
        src_we_o  = 1'b0;
        rsp0      = c_wrf_rsp_stalled;
        rsp1      = c_wrf_rsp_stalled;
        grant_o   = 2'b00;
        case (state)
            OWN0: begin
                src_dat_o = snk0_dat_i;
                src_adr_o = snk0_adr_i;
                src_sel_o = snk0_sel_i;
                src_cyc_o = snk0_cyc_i;
                src_stb_o = snk0_stb_i;
                src_we_o  = snk0_we_i;
                rsp0      = src_rsp;
                grant_o   = 2'b01;
            end
            OWN1: begin
                src_dat_o = snk1_dat_i;
                src_adr_o = snk1_adr_i;
                src_sel_o = snk1_sel_i;
                src_cyc_o = snk1_cyc_i;
                src_stb_o = snk1_stb_i;
                src_we_o  = snk1_we_i;
                rsp1      = src_rsp;
                grant_o   = 2'b10;
            end
            default: ;
        endcase
    end

    assign snk0_stall_o = rsp0.stall;
    assign snk0_ack_o   = rsp0.ack;
    assign snk0_err_o   = rsp0.err;
    assign snk1_stall_o = rsp1.stall;
    assign snk1_ack_o   = rsp1.ack;
    assign snk1_err_o   = rsp1.err;

`ifdef WRF_ARB_STATS_EN
    logic frame_done0;
    logic frame_done1;

    // One pulse per OWNn -> IDLE transition.
    assign frame_done0 = (state == OWN0) && !snk0_cyc_i;
    assign frame_done1 = (state == OWN1) && !snk1_cyc_i;

    wrf_arb_stats u_stats (
        .clk     (clk_sys_i),
        .rst     (rst_i),
        .clr     (stats_clr_i),
        .done0   (frame_done0),
        .done1   (frame_done1),
        .frames0 (frames0_o),
        .frames1 (frames1_o)
    );
`endif

endmodule

// File: tb/tb_wrf_frame_arbiter.sv
`timescale 1ns/1ps
// Purpose : self-checking bench for wrf_frame_arbiter (vector table + frame scoreboard).
// Latency : n/a.
// Backpress: bench sink model can stall every other cycle; acks one cycle after acceptance.
module tb_wrf_frame_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [15:0] snk0_dat = '0, snk1_dat = '0;
    logic [1:0]  snk0_adr = 2'b01, snk1_adr = 2'b10;
    logic [1:0]  snk0_sel = 2'b11, snk1_sel = 2'b01;
    logic        snk0_cyc = 1'b0, snk1_cyc = 1'b0;
    logic        snk0_stb = 1'b0, snk1_stb = 1'b0;
    logic        snk0_we  = 1'b1, snk1_we  = 1'b0;
    logic        snk0_stall, snk0_ack, snk0_err;
    logic        snk1_stall, snk1_ack, snk1_err;

    logic [15:0] src_dat;
    logic [1:0]  src_adr, src_sel;
    logic        src_cyc, src_stb, src_we;
    logic        src_stall = 1'b0, src_ack = 1'b0, src_err = 1'b0;
    logic [1:0]  grant;

`ifdef WRF_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] frames0, frames1;
`endif

    wrf_frame_arbiter u_dut (
        .clk_sys_i    (clk),
        .rst_i        (rst),
        .snk0_dat_i   (snk0_dat),
        .snk0_adr_i   (snk0_adr),
        .snk0_sel_i   (snk0_sel),
        .snk0_cyc_i   (snk0_cyc),
        .snk0_stb_i   (snk0_stb),
        .snk0_we_i    (snk0_we),
        .snk0_stall_o (snk0_stall),
        .snk0_ack_o   (snk0_ack),
        .snk0_err_o   (snk0_err),
        .snk1_dat_i   (snk1_dat),
        .snk1_adr_i   (snk1_adr),
        .snk1_sel_i   (snk1_sel),
        .snk1_cyc_i   (snk1_cyc),
        .snk1_stb_i   (snk1_stb),
        .snk1_we_i    (snk1_we),
        .snk1_stall_o (snk1_stall),
        .snk1_ack_o   (snk1_ack),
        .snk1_err_o   (snk1_err),
        .src_dat_o    (src_dat),
        .src_adr_o    (src_adr),
        .src_sel_o    (src_sel),
        .src_cyc_o    (src_cyc),
        .src_stb_o    (src_stb),
        .src_we_o     (src_we),
        .src_stall_i  (src_stall),
        .src_ack_i    (src_ack),
        .src_err_i    (src_err),
`ifdef WRF_ARB_STATS_EN
        .stats_clr_i  (stats_clr),
        .frames0_o    (frames0),
        .frames1_o    (frames1),
`endif
        .grant_o      (grant)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- cycle counter, sink model, monitor ----------------
    int          cyc_cnt    = 0;
    logic        model_en   = 1'b0;
    logic        stall_mode = 1'b0;
    logic        mon_en     = 1'b0;
    logic [16:0] sb[$];              // {port, data} in expected fabric order
    logic [1:0]  grant_q[$];         // de-duplicated grant history
    logic [1:0]  last_g   = 2'b00;
    logic        prev_cyc = 1'b0;
    int          rise_cycle = 0;
    int          req_cycle[2];
    int          acks[2];
    int          viol = 0;
    int          words_seen = 0;

    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    // Sink: acks each accepted word one cycle later, optional alternate-cycle stall.
    initial begin
        logic acc;
        forever begin
            @(negedge clk);
            acc = model_en && src_cyc && src_stb && !src_stall;
            @(posedge clk);
            #1;
            if (model_en) begin
                src_ack   = acc;
                src_stall = stall_mode ? cyc_cnt[0] : 1'b0;
                src_err   = 1'b0;
            end
        end
    end

    initial begin
        logic [16:0] exp_w;
        acks[0] = 0;
        acks[1] = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (grant !== last_g) begin
                    grant_q.push_back(grant);
                    last_g = grant;
                end
                if (snk0_ack) acks[0]++;
                if (snk1_ack) acks[1]++;
                if (src_cyc && !prev_cyc) rise_cycle = cyc_cnt;
                prev_cyc = src_cyc;
                if (grant != 2'b01 && (!snk0_stall || snk0_ack || snk0_err)) viol++;
                if (grant != 2'b10 && (!snk1_stall || snk1_ack || snk1_err)) viol++;
                if (grant == 2'b01 && (snk0_stall !== src_stall || snk0_ack !== src_ack)) viol++;
                if (grant == 2'b10 && (snk1_stall !== src_stall || snk1_ack !== src_ack)) viol++;
                #2;
                if (src_cyc && src_stb && !src_stall) begin
                    words_seen++;
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_extra: got word 0x%0h, want none", src_dat);
                    end else begin
                        exp_w = sb.pop_front();
                        check("sb_word", {15'd0, grant[1], src_dat}, {15'd0, exp_w});
                    end
                end
            end
        end
    end

    // ---------------- requester helpers ----------------
    task automatic drive(input int p, input logic c, input logic s, input logic [15:0] d);
        if (p == 0) begin snk0_cyc = c; snk0_stb = s; snk0_dat = d; end
        else        begin snk1_cyc = c; snk1_stb = s; snk1_dat = d; end
    endtask

    function automatic logic stall_of(input int p);
        return (p == 0) ? snk0_stall : snk1_stall;
    endfunction

    // One frame of n words; abort_at>0 pulses reset once that many words went out.
    task automatic send_frame(input int p, input int n, input logic [15:0] base, input int abort_at);
        int idx = 0;
        int guard = 0;
        int ack_base;
        logic [15:0] w;
        ack_base = acks[p];
        @(posedge clk);
        #1;
        req_cycle[p] = cyc_cnt;
        drive(p, 1'b1, 1'b1, base);
        while (idx < n) begin
            @(negedge clk);
            if (!stall_of(p)) begin
                w = base + 16'(idx);
                sb.push_back({p[0], w});
                idx++;
            end
            @(posedge clk);
            #1;
            if (abort_at != 0 && idx == abort_at) begin
                rst = 1'b1;
                drive(p, 1'b1, 1'b1, base + 16'(idx));
                @(negedge clk);
                check("rst_pending_grant", {30'd0, grant}, (p == 0) ? 32'd1 : 32'd2);
                if (!stall_of(p)) begin
                    w = base + 16'(idx);
                    sb.push_back({p[0], w});
                end
                @(posedge clk);
                #1;
                rst = 1'b0;
                drive(p, 1'b0, 1'b0, 16'd0);
                @(negedge clk);
                check("rst_src_cyc", {31'd0, src_cyc}, 32'd0);
                check("rst_grant", {30'd0, grant}, 32'd0);
                check("rst_owner_stall", {31'd0, stall_of(p)}, 32'd1);
                return;
            end
            if (idx < n) drive(p, 1'b1, 1'b1, base + 16'(idx));
            else         drive(p, 1'b1, 1'b0, base);
            guard++;
            if (guard > 2000) begin
                total++;
                bad++;
                $display("FAIL frame_timeout_p%0d: got %0d words, want %0d", p, idx, n);
                drive(p, 1'b0, 1'b0, 16'd0);
                return;
            end
        end
        guard = 0;
        while ((acks[p] - ack_base) < n && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("acks_p%0d", p), acks[p] - ack_base, n);
        @(posedge clk);
        #1;
        drive(p, 1'b0, 1'b0, 16'd0);
    endtask

    task automatic check_grants(input string name, input logic [1:0] exp[$]);
        check({name, "_len"}, grant_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < grant_q.size(); i++)
            check($sformatf("%s_%0d", name, i), {30'd0, grant_q[i]}, {30'd0, exp[i]});
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        c0, s0;
        logic [15:0] d0;
        logic        c1, s1;
        logic [15:0] d1;
        logic [2:0]  in_rsp;   // {src_stall, src_ack, src_err}
        logic [1:0]  e_grant;
        logic        e_cyc;
        logic [15:0] e_dat;
        logic [2:0]  e_rsp0;   // {stall, ack, err} seen by port 0
        logic [2:0]  e_rsp1;
    } vec_t;

    function automatic vec_t mk(input logic c0, s0, input logic [15:0] d0,
                                input logic c1, s1, input logic [15:0] d1,
                                input logic [2:0] ir, input logic [1:0] eg, input logic ec,
                                input logic [15:0] ed, input logic [2:0] e0, e1);
        vec_t v;
        v.c0 = c0; v.s0 = s0; v.d0 = d0; v.c1 = c1; v.s1 = s1; v.d1 = d1;
        v.in_rsp = ir; v.e_grant = eg; v.e_cyc = ec; v.e_dat = ed;
        v.e_rsp0 = e0; v.e_rsp1 = e1;
        return v;
    endfunction

    initial begin
        vec_t        vecs[$];
        logic [1:0]  eg[$];
        logic [30:0] obs, expv;
        logic        e_stb, e_we;
        logic [1:0]  e_adr, e_sel;

        // row: inputs this cycle -> outputs sampled this cycle (state from previous edge)
        vecs.push_back(mk(0,0,16'h0000, 0,0,16'h0000, 3'b000, 2'b00,0,16'h0000, 3'b100,3'b100));
        vecs.push_back(mk(1,1,16'hA001, 1,1,16'hB001, 3'b010, 2'b00,0,16'h0000, 3'b100,3'b100));
        vecs.push_back(mk(1,1,16'hA002, 1,1,16'hB002, 3'b100, 2'b01,1,16'hA002, 3'b100,3'b100));
        vecs.push_back(mk(1,1,16'hA003, 1,1,16'hB003, 3'b011, 2'b01,1,16'hA003, 3'b011,3'b100));
        vecs.push_back(mk(0,0,16'hA004, 1,1,16'hB004, 3'b010, 2'b01,0,16'hA004, 3'b010,3'b100));
        vecs.push_back(mk(0,0,16'h0000, 1,1,16'hB005, 3'b011, 2'b00,0,16'h0000, 3'b100,3'b100));
        vecs.push_back(mk(1,1,16'hA006, 1,1,16'hB006, 3'b010, 2'b10,1,16'hB006, 3'b100,3'b010));
        vecs.push_back(mk(1,1,16'hA007, 1,0,16'hB007, 3'b101, 2'b10,1,16'hB007, 3'b100,3'b101));
        vecs.push_back(mk(1,1,16'hA008, 0,0,16'hB008, 3'b000, 2'b10,0,16'hB008, 3'b100,3'b000));
        vecs.push_back(mk(1,1,16'hA009, 1,1,16'hB009, 3'b000, 2'b00,0,16'h0000, 3'b100,3'b100));
        vecs.push_back(mk(1,1,16'hA00A, 1,1,16'hB00A, 3'b000, 2'b01,1,16'hA00A, 3'b000,3'b100));
        vecs.push_back(mk(0,0,16'h0000, 0,0,16'h0000, 3'b000, 2'b01,0,16'h0000, 3'b000,3'b100));
        vecs.push_back(mk(0,0,16'h0000, 0,0,16'h0000, 3'b000, 2'b00,0,16'h0000, 3'b100,3'b100));

        // reset state
        @(posedge clk);
        @(negedge clk);
        obs = {grant, src_cyc, src_stb, src_we, src_adr, src_sel, src_dat,
               snk0_stall, snk0_ack, snk0_err, snk1_stall, snk1_ack, snk1_err};
        check("reset_state", {1'b0, obs}, {1'b0, 2'b00, 3'b000, 2'b00, 2'b00, 16'h0000, 3'b100, 3'b100});
        idle_cycles(2);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            snk0_cyc = vecs[i].c0; snk0_stb = vecs[i].s0; snk0_dat = vecs[i].d0;
            snk1_cyc = vecs[i].c1; snk1_stb = vecs[i].s1; snk1_dat = vecs[i].d1;
            {src_stall, src_ack, src_err} = vecs[i].in_rsp;
            @(negedge clk);
            e_stb = 1'b0; e_we = 1'b0; e_adr = 2'b00; e_sel = 2'b00;
            if (vecs[i].e_grant == 2'b01) begin
                e_stb = vecs[i].s0; e_we = 1'b1; e_adr = 2'b01; e_sel = 2'b11;
            end else if (vecs[i].e_grant == 2'b10) begin
                e_stb = vecs[i].s1; e_we = 1'b0; e_adr = 2'b10; e_sel = 2'b01;
            end
            obs  = {grant, src_cyc, src_stb, src_we, src_adr, src_sel, src_dat,
                    snk0_stall, snk0_ack, snk0_err, snk1_stall, snk1_ack, snk1_err};
            expv = {vecs[i].e_grant, vecs[i].e_cyc, e_stb, e_we, e_adr, e_sel,
                    vecs[i].e_dat, vecs[i].e_rsp0, vecs[i].e_rsp1};
            check($sformatf("vec%0d", i), {1'b0, obs}, {1'b0, expv});
        end

        // ---------------- frame-level sequences ----------------
        @(posedge clk);
        #1;
        {src_stall, src_ack, src_err} = 3'b000;
        rst = 1'b1;
        idle_cycles(2);
        rst = 1'b0;
        model_en = 1'b1;
        mon_en   = 1'b1;
        idle_cycles(1);

        // tie right after reset: port 0 first, idle gap, then port 1
        grant_q.delete();
        fork
            send_frame(0, 4, 16'h1000, 0);
            send_frame(1, 4, 16'h2000, 0);
        join
        idle_cycles(2);
        eg = '{2'b01, 2'b00, 2'b10, 2'b00};
        check_grants("tie_grants", eg);

        // single 30-word frame from port 0
        grant_q.delete();
        words_seen = 0;
        send_frame(0, 30, 16'h3000, 0);
        idle_cycles(2);
        check("latency_cyc", rise_cycle - req_cycle[0], 1);
        check("frame30_words", words_seen, 30);
        eg = '{2'b01, 2'b00};
        check_grants("frame30_grants", eg);

        // port 0 back-to-back while port 1 keeps requesting
        grant_q.delete();
        viol = 0;
        fork
            begin
                for (int k = 0; k < 3; k++) send_frame(0, 5, 16'h4000 + 16'(k * 16), 0);
            end
            begin
                @(posedge clk);
                for (int k = 0; k < 2; k++) send_frame(1, 5, 16'h4800 + 16'(k * 16), 0);
            end
        join
        idle_cycles(2);
        eg = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        check_grants("rr_grants", eg);
        check("rr_nonowner_viol", viol, 0);

        // stalled every other cycle
        viol = 0;
        words_seen = 0;
        stall_mode = 1'b1;
        send_frame(0, 10, 16'h5000, 0);
        stall_mode = 1'b0;
        idle_cycles(3);
        check("stall_words", words_seen, 10);
        check("stall_viol", viol, 0);
        check("stall_sb_empty", sb.size(), 0);

        // reset in the middle of a frame, then a clean tie
        send_frame(0, 12, 16'h6000, 5);
        idle_cycles(2);
        check("abort_sb_empty", sb.size(), 0);
        grant_q.delete();
        fork
            send_frame(0, 3, 16'h7000, 0);
            send_frame(1, 3, 16'h7100, 0);
        join
        idle_cycles(2);
        eg = '{2'b01, 2'b00, 2'b10, 2'b00};
        check_grants("post_rst_grants", eg);

`ifdef WRF_ARB_STATS_EN
        stats_clr = 1'b1;
        idle_cycles(1);
        stats_clr = 1'b0;
        for (int k = 0; k < 3; k++) send_frame(0, 2, 16'h8000, 0);
        for (int k = 0; k < 2; k++) send_frame(1, 2, 16'h8100, 0);
        idle_cycles(2);
        check("frames0_cnt", {16'd0, frames0}, 32'd3);
        check("frames1_cnt", {16'd0, frames1}, 32'd2);
        force u_dut.u_stats.cnt0 = 16'hFFFF;
        #1;
        release u_dut.u_stats.cnt0;
        send_frame(0, 2, 16'h8200, 0);
        idle_cycles(2);
        check("frames0_wrap", {16'd0, frames0}, 32'd0);
        stats_clr = 1'b1;
        idle_cycles(1);
        stats_clr = 1'b0;
        @(negedge clk);
        check("clr_frames0", {16'd0, frames0}, 32'd0);
        check("clr_frames1", {16'd0, frames1}, 32'd0);
`endif

        idle_cycles(2);
        check("final_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: got no completion, want finish before time limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
